fifo_frame_reader: RTL
======================

# fifo_frame_reader

Downstream consumer of the byte-packing FIFO's 32-bit read port. It drains words with `fifo_r_en` and groups every `FRAME_WORDS` payload words into a frame. Each frame ends with a one-word trailer holding the 32-bit modular sum of its payload. Frames go out on a valid/ready word stream toward the link/packet stage. The block absorbs the FIFO's one-cycle read latency and its "short read" case (`fifo_valid_out`=0) without losing or duplicating words.

## Interface
- `FRAME_WORDS`, default 4: payload words per frame. Legal range is 1..255.
- `WORD_WIDTH`, default 32: word width. Fixed by the FIFO read port; do not override.
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_valid_out` in 1: the word returned for the previous cycle's `fifo_r_en` is valid. 0 means fewer than 4 bytes were stored and no word was returned.
- `fifo_data_out` in `WORD_WIDTH`: returned word. Meaningful only when `fifo_valid_out`=1.
- `fifo_r_en` out 1: read request to the FIFO.
- `frame_data` out `WORD_WIDTH`: output word (payload or trailer).
- `frame_valid` out 1: `frame_data` is valid.
- `frame_ready` in 1: downstream accepts `frame_data` this cycle.
- `frame_last` out 1: the current word is the trailer.
- `frame_count` out 16: number of completed frames. Wraps modulo 2^16.

## Operation
- Reset values: `fifo_r_en`=0, `frame_valid`=0, `frame_data`=0, `frame_last`=0, `frame_count`=0. Also cleared: skid queue, in-flight flag, word counters, running sum, FSM state (`PAYLOAD`).
- FSM has two states.
  - `PAYLOAD`: emits payload words from the skid queue. After payload word `FRAME_WORDS` is accepted, go to `TRAILER`.
  - `TRAILER`: presents `frame_data`=sum with `frame_last`=1. On acceptance: increment `frame_count`, clear sum and counters, return to `PAYLOAD`.
- `fifo_r_en` is asserted only when all of the following hold:
  - state is `PAYLOAD`;
  - `fifo_empty`=0;
  - `requested` < `FRAME_WORDS`;
  - `queue_count` + `inflight` < 2.
  - Definition: `requested` = words accepted + queued + in flight in the current frame.
- No prefetch across a frame boundary.
- Read return: `inflight` is set in the cycle after `fifo_r_en`. In that cycle:
  - `fifo_valid_out`=1: push `fifo_data_out` into the skid queue.
  - `fifo_valid_out`=0: nothing is pushed, and the request slot is released, so `requested` drops by 1.
- Skid queue: 2 entries, in order. It feeds an output register (`frame_data`/`frame_valid`). The output register loads whenever it is empty or being accepted (`frame_valid`&&`frame_ready`).
- Sum: `sum <= sum + word` mod 2^32 on each payload-word acceptance. Carries are discarded.
- Push and pop of the queue in the same cycle are legal. Count is unchanged.
- `FRAME_WORDS`=1: each frame is 1 payload word plus 1 trailer.
- Reset mid-frame: the partial frame is discarded. Any word returning from the FIFO in the cycle after reset is ignored. The next frame starts with sum 0.

## Timing
- First word latency: `fifo_r_en` at cycle t → queue write at t+1 → `frame_valid`=1 at t+2 at the earliest.
- Sustained throughput with `frame_ready`=1 and a non-empty FIFO: 1 payload word per cycle, then 1 trailer cycle.
  - The first read of the next frame issues in the trailer-acceptance cycle plus 1.
- Handshake:
  - While `frame_valid`=1 and `frame_ready`=0, `frame_data` and `frame_last` hold stable.
  - `frame_valid` never drops without acceptance, except on reset.
- Backpressure: at most 2 words are buffered beyond the output register. `fifo_r_en` deasserts in the same cycle the limit is reached.
- `frame_count` updates in the cycle after trailer acceptance.

## Structure
- Shared package `fifo_pkg`:
  - `WORD_WIDTH`=32;
  - typedef `word_t`;
  - FSM enum `frame_state_e` {`PAYLOAD`, `TRAILER`};
  - `FRAME_CNT_WIDTH`=16.
- Sub-module `fifo_rd_skid`: 2-entry in-order queue with push, pop, count, and head data. Top level holds the FSM, request accounting, sum, and output register.

## Test plan
- Reset: hold `reset`=1 with the FIFO non-empty for 5 cycles → `fifo_r_en`=0, `frame_valid`=0, `frame_count`=0 throughout.
- Basic frame (`FRAME_WORDS`=4, `frame_ready`=1): FIFO supplies 0x1, 0x2, 0x3, 0x4 → payload 1, 2, 3, 4, then trailer 0x0000000A with `frame_last`=1; `frame_count`=1.
- Sum wrap: payload 0xFFFFFFFF, 0x00000002, 0x0, 0x0 → trailer 0x00000001.
- Backpressure: drop `frame_ready` for 6 cycles after word 2 → `frame_data` stays at 2 and `fifo_r_en` deasserts within 2 reads; after release, words 3 and 4 and the trailer appear once each, in order.
- Short read: the FIFO holds 3 bytes, so `fifo_valid_out`=0 → no word emitted and `requested` is unchanged. After 1 more byte is written, the next read yields the word and the frame completes normally.
- Reset mid-frame after 2 accepted words → all outputs return to reset values. The following 4 words 0x5, 0x5, 0x5, 0x5 produce trailer 0x00000014 and `frame_count`=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side frame logic.
package fifo_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int FRAME_CNT_WIDTH = 16;
    // Payload word counters; FRAME_WORDS tops out at 255.
    localparam int WCNT_WIDTH      = 8;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [WCNT_WIDTH-1:0] wcnt_t;

    typedef enum logic {
        PAYLOAD = 1'b0,
        TRAILER = 1'b1
    } frame_state_e;

    // Trailer checksum step: plain modular add, carry out is dropped.
    function automatic word_t sum_add(input word_t a, input word_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order queue between the FIFO read return and the output
// register. When empty, the head falls through to the word being pushed so a
// returning word can reach the output register in the same cycle.
module fifo_rd_skid
    import fifo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  word_t      push_data,
    input  logic       pop,
    output logic       head_valid,
    output word_t      head_data,
    output logic [1:0] count
);

    word_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  stored;
    logic  store;
    logic  take;

    assign stored     = (count != 2'd0);
    assign head_valid = stored || push;
    assign head_data  = stored ? mem[rd_ptr] : push_data;
    // A pop against an empty queue consumes the pushed word directly.
    assign take       = pop && stored;
    assign store      = push && !(pop && !stored);

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (take) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, store} - {1'b0, take};
        end
    end

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains the FIFO read port into frames of FRAME_WORDS payload words, each
// followed by a trailer word carrying the modular sum of the payload.
module fifo_frame_reader
    import fifo_pkg::*;
#(
    parameter int FRAME_WORDS = 4,
    parameter int WORD_WIDTH  = fifo_pkg::WORD_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fifo_empty,
    input  logic                       fifo_valid_out,
    input  logic [WORD_WIDTH-1:0]      fifo_data_out,
    output logic                       fifo_r_en,
    output logic [WORD_WIDTH-1:0]      frame_data,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic                       frame_last,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam wcnt_t FW       = wcnt_t'(FRAME_WORDS);
    localparam wcnt_t LAST_IDX = wcnt_t'(FRAME_WORDS - 1);

    frame_state_e state;
    wcnt_t        requested;   // accepted + output reg + queued + in flight
    wcnt_t        accepted;    // payload words accepted in this frame
    logic         inflight;    // a read was issued last cycle
    word_t        sum;

    logic         push;
    logic         pop;
    logic         short_ret;
    logic         head_valid;
    word_t        head_data;
    logic [1:0]   q_count;
    logic [2:0]   occ;
    logic         accept;
    logic         out_free;
    logic         last_pay;

    fifo_rd_skid u_skid (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (fifo_data_out),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (q_count)
    );

    assign accept    = frame_valid && frame_ready;
    assign out_free  = !frame_valid || accept;
    assign occ       = {1'b0, q_count} + {2'b00, inflight};
    assign push      = inflight && fifo_valid_out;
    assign short_ret = inflight && !fifo_valid_out;
    assign last_pay  = (state == PAYLOAD) && accept && (accepted == LAST_IDX);
    // Only this frame's words are ever requested, so the queue is empty by
    // the time the last payload word leaves; the guard keeps it that way.
    assign pop       = (state == PAYLOAD) && out_free && !last_pay && head_valid;

    // Read request: combinational so it drops in the same cycle the skid
    // limit or the frame's word budget is reached.
    assign fifo_r_en = !reset && (state == PAYLOAD) && !fifo_empty &&
                       (requested < FW) && (occ < 3'd2);

    // Request accounting: a short read returns its slot to the frame budget.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight  <= 1'b0;
            requested <= '0;
        end else begin
            inflight <= fifo_r_en;
            if ((state == TRAILER) && accept) begin
                requested <= '0;
            end else begin
                requested <= requested + wcnt_t'(fifo_r_en) - wcnt_t'(short_ret);
            end
        end
    end

    // Frame FSM with the output register, running sum and frame counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= PAYLOAD;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_last  <= 1'b0;
            accepted    <= '0;
            sum         <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                PAYLOAD: begin
                    if (accept) begin
                        sum      <= sum_add(sum, frame_data);
                        accepted <= accepted + wcnt_t'(1);
                    end
                    if (last_pay) begin
                        frame_data  <= sum_add(sum, frame_data);
                        frame_last  <= 1'b1;
                        frame_valid <= 1'b1;
                        state       <= TRAILER;
                    end else if (pop) begin
                        frame_data  <= head_data;
                        frame_valid <= 1'b1;
                    end else if (accept) begin
                        frame_valid <= 1'b0;
                    end
                end
                TRAILER: begin
                    if (accept) begin
                        frame_valid <= 1'b0;
                        frame_last  <= 1'b0;
                        sum         <= '0;
                        accepted    <= '0;
                        frame_count <= frame_count + 1'b1;
                        state       <= PAYLOAD;
                    end
                end
                default: state <= PAYLOAD;
            endcase
        end
    end

endmodule
